// File: rtl/key_cmd_decoder.sv
// rtl/key_cmd_decoder.sv - PS/2 scan-code to per-game-step command decoder
module key_cmd_decoder #(
    parameter bit ENABLE_WASD = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       tick,
    output logic       left,
    output logic       right,
    output logic       rotate,
    output logic       start,
    output logic       parse_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    state_t     state_q, state_d;
    logic [3:0] pend_q, pend_d;   // {start, rotate, right, left}
    logic [3:0] cmd_q, cmd_d;
    logic       err_q, err_d;
    logic       make_vld;
    logic       make_ext;
    logic [3:0] make_bits;
    logic [3:0] pend_base;

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        make_vld = 1'b0;
        make_ext = 1'b0;
        if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_code == CODE_EXT)      state_d = S_EXT;
                    else if (scan_code == CODE_BRK) state_d = S_BRK;
                    else                            make_vld = 1'b1;
                end
                S_EXT: begin
                    if (scan_code == CODE_BRK) begin
                        state_d = S_EXT_BRK;
                    end else if (scan_code != CODE_EXT) begin
                        make_vld = 1'b1;
                        make_ext = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    // The byte after F0 is the released key; a prefix here means a garbled stream.
                    if (scan_code == CODE_EXT || scan_code == CODE_BRK) err_d = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        make_bits = 4'b0000;
        if (make_vld) begin
            if (make_ext) begin
                case (scan_code)
                    8'h6B:   make_bits = 4'b0001;
                    8'h74:   make_bits = 4'b0010;
                    8'h75:   make_bits = 4'b0100;
                    default: make_bits = 4'b0000;
                endcase
            end else begin
                case (scan_code)
                    8'h29:   make_bits = 4'b1000;
                    8'h1C:   make_bits = ENABLE_WASD ? 4'b0001 : 4'b0000;
                    8'h23:   make_bits = ENABLE_WASD ? 4'b0010 : 4'b0000;
                    8'h1D:   make_bits = ENABLE_WASD ? 4'b0100 : 4'b0000;
                    default: make_bits = 4'b0000;
                endcase
            end
        end
    end

    always_comb begin
        cmd_d     = cmd_q;
        pend_base = pend_q;
        if (tick) begin
            cmd_d = pend_q;
            if (pend_q[0] && pend_q[1]) cmd_d[1:0] = 2'b00;
            pend_base = 4'b0000;
        end
        // A make arriving on the tick cycle lands after the clear so it survives into the next step.
        pend_d = pend_base | make_bits;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= 4'b0000;
            cmd_q   <= 4'b0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
        end
    end

    assign left      = cmd_q[0];
    assign right     = cmd_q[1];
    assign rotate    = cmd_q[2];
    assign start     = cmd_q[3];
    assign parse_err = err_q;

endmodule

// File: doc/key_cmd_decoder.md
# key_cmd_decoder

Converts the PS/2 keyboard byte stream into the `left`, `right`, `rotate` and `start` command levels that the game datapath and game state machine sample. Sits directly upstream of the game core, between the PS/2 byte receiver and the slow game-step domain. Decodes make/break/extended prefixes, latches each key press as a pending command, and presents the commands once per game step so that no press is lost and none is applied twice.

## Interface

Parameters:
- `ENABLE_WASD`, default 1: when 1, W/A/D also map to rotate/left/right; when 0, only the arrow keys map.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `scan_code`  in  8  byte from the PS/2 receiver; valid only when `scan_valid`=1.
- `scan_valid`  in  1  one-cycle strobe; at most one byte per cycle.
- `tick`  in  1  one-cycle strobe marking a game step; commands are transferred to the outputs on this cycle.
- `left`  out  1  move-left command for the current game step.
- `right`  out  1  move-right command for the current game step.
- `rotate`  out  1  rotate command for the current game step.
- `start`  out  1  start command for the current game step.
- `parse_err`  out  1  sticky flag: an unexpected byte arrived in a prefix state.

## Operation

- Parser FSM, 4 states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte is a non-extended make code -> decode, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte is an extended make code -> decode, go to IDLE.
  - BRK: any byte -> IDLE (break, no command). E0 or F0 here sets `parse_err` and returns to IDLE.
  - EXT_BRK: any byte -> IDLE (break, no command). E0 or F0 here sets `parse_err` and returns to IDLE.
- Make-code map:
  - Extended: 6B -> left, 74 -> right, 75 -> rotate.
  - Non-extended: 29 (space) -> start.
  - If `ENABLE_WASD`=1, non-extended: 1C -> left, 23 -> right, 1D -> rotate.
  - All other codes are ignored and do not set `parse_err`.
- Auto-repeat make codes are treated like fresh presses.
- Pending register: 4 bits (`p_left`, `p_right`, `p_rot`, `p_start`). A decoded make sets its bit.
- On `tick`:
  - Outputs load from the pending bits, then the pending bits clear.
  - Conflict rule: if `p_left` and `p_right` are both set, `left` and `right` both load 0. `rotate` and `start` are unaffected.
- Outputs hold their value between ticks. Commands are never re-asserted without a new make code.
- `parse_err` clears only on reset.

## Timing

- Reset (`reset`=0): state=IDLE; pending=0; `left`/`right`/`rotate`/`start`=0; `parse_err`=0. Asynchronous assertion; state is held while `reset`=0.
- Byte-to-pending latency: a make byte with `scan_valid`=1 in cycle N sets its pending bit visible in cycle N+1.
- Tick-to-output latency: `tick` in cycle N updates the outputs in cycle N+1.
- Simultaneous `scan_valid` and `tick` in the same cycle:
  - The outputs load the pending bits as they were before that cycle.
  - The new make sets its pending bit after the clear, so it is carried into the next window and not dropped.
- Multiple presses of the same key before a tick collapse to a single command.
- `scan_valid` with an incomplete prefix across a tick: the FSM state is unaffected by `tick`.
- Reset mid-sequence (e.g. after E0): the FSM returns to IDLE. The next byte 6B is decoded as non-extended and is therefore ignored.

## Test plan

- Reset, then E0 6B, then `tick` -> `left`=1 from the cycle after the tick, `right`=`rotate`=`start`=0. A second `tick` with no bytes -> `left`=0.
- E0 F0 74 (right-arrow break), then `tick` -> all outputs 0, FSM in IDLE, `parse_err`=0.
- E0 6B, E0 74, 1D (with `ENABLE_WASD`=1), then `tick` -> `left`=0, `right`=0, `rotate`=1.
- Byte 29 with `scan_valid` and `tick` in the same cycle, pending empty -> after that tick `start`=0. After the next `tick`, `start`=1.
- F0 F0 -> `parse_err`=1 and the FSM returns to IDLE. A following E0 75, `tick` -> `rotate`=1, `parse_err` still 1.
- E0, then `reset`=0 for 1 cycle, then 6B, `tick` -> all outputs 0. Same stream with `ENABLE_WASD`=0 and byte 1C -> all outputs 0.
